// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART arbiter types, widths and command bytes
package uart_pkg;

  localparam int BYTE_W  = 8;
  localparam int GRANT_W = 3;

  // Command bytes also recognised by the RX decoder
  localparam logic [BYTE_W-1:0] CMD_R = 8'h52;
  localparam logic [BYTE_W-1:0] CMD_L = 8'h4C;
  localparam logic [BYTE_W-1:0] CMD_U = 8'h55;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_DONE,
    HOLD
  } arb_state_e;

  function automatic logic [GRANT_W-1:0] wrap_inc(input logic [GRANT_W-1:0] idx, input int n);
    if (int'(idx) + 1 >= n) return '0;
    return idx + GRANT_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotate-and-priority-encode: first set request at or after ptr_i, wrapping
module rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0]   req_i,
  input  logic [GRANT_W-1:0] ptr_i,
  output logic [GRANT_W-1:0] winner_o,
  output logic               found_o
);

  localparam int EXT_W = 1 << GRANT_W;

  logic [EXT_W-1:0]   req_ext;
  logic [GRANT_W-1:0] idx;

  // Walk offsets from the far end down so the nearest offset to ptr_i wins last
  always_comb begin
    req_ext            = '0;
    req_ext[N_REQ-1:0] = req_i;
    winner_o           = '0;
    found_o            = 1'b0;
    idx                = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (ptr_i >= GRANT_W'(N_REQ - k)) idx = ptr_i - GRANT_W'(N_REQ - k);
      else                              idx = ptr_i + GRANT_W'(k);
      if (req_ext[idx]) begin
        winner_o = idx;
        found_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin owner of the shared UART transmitter with packet lock
// UART_TX_ARB_PRIO_EN: requester 0 wins every IDLE arbitration, the rest rotate.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int LOCK_TO = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        ack,
  output logic                    tx_start,
  output logic [BYTE_W-1:0]       tx_data,
  input  logic                    tx_busy,
  input  logic                    tx_done,
  output logic [GRANT_W-1:0]      grant_id,
  output logic                    arb_busy
);

  localparam int               EXT_W    = 1 << GRANT_W;
  localparam int               CNT_W    = $clog2(LOCK_TO + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TO - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  arb_state_e         state_q;
  logic [GRANT_W-1:0] rr_ptr_q;
  logic [GRANT_W-1:0] grant_q;
  logic               lock_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               tx_start_q;
  logic [BYTE_W-1:0]  tx_data_q;
  logic [N_REQ-1:0]   ack_q;
  logic               arb_busy_q;

  logic [EXT_W-1:0]   req_ext;
  logic [EXT_W-1:0]   last_ext;
  logic [BYTE_W-1:0]  owner_data;
  logic               owner_req;
  logic               owner_last;
  logic [N_REQ-1:0]   pick_req;
  logic [GRANT_W-1:0] pick_idx;
  logic               pick_found;
  logic               win_valid;
  logic [GRANT_W-1:0] win_idx;

  always_comb begin
    req_ext             = '0;
    last_ext            = '0;
    owner_data          = '0;
    req_ext[N_REQ-1:0]  = req;
    last_ext[N_REQ-1:0] = req_last;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == GRANT_W'(i)) owner_data = req_data[BYTE_W*i +: BYTE_W];
    end
  end

  assign owner_req  = req_ext[grant_q];
  assign owner_last = last_ext[grant_q];

`ifdef UART_TX_ARB_PRIO_EN
  // Requester 0 bypasses the rotation entirely; it never breaks into a locked packet
  assign pick_req  = {req[N_REQ-1:1], 1'b0};
  assign win_valid = req[0] | pick_found;
  assign win_idx   = req[0] ? '0 : pick_idx;
`else
  assign pick_req  = req;
  assign win_valid = pick_found;
  assign win_idx   = pick_idx;
`endif

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req_i    (pick_req),
    .ptr_i    (rr_ptr_q),
    .winner_o (pick_idx),
    .found_o  (pick_found)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      lock_q     <= 1'b0;
      cnt_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      ack_q      <= '0;
      arb_busy_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      ack_q      <= '0;
      unique case (state_q)
        IDLE: begin
          if (win_valid) begin
            grant_q    <= win_idx;
            state_q    <= SEND;
            arb_busy_q <= 1'b1;
          end
        end
        SEND: begin
          if (!owner_req) begin
            state_q    <= IDLE;
            arb_busy_q <= 1'b0;
          end else if (!tx_busy) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= owner_data;
            ack_q      <= N_REQ'(1) << grant_q;
            lock_q     <= !owner_last;
            state_q    <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (tx_done) begin
            if (lock_q) begin
              state_q <= HOLD;
              cnt_q   <= '0;
            end else begin
              rr_ptr_q   <= wrap_inc(grant_q, N_REQ);
              state_q    <= IDLE;
              arb_busy_q <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (owner_req) begin
            state_q <= SEND;
          end else begin
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
            // Owner went quiet too long: give the transmitter back to the rotation
            if (cnt_q >= CNT_LAST) begin
              lock_q     <= 1'b0;
              rr_ptr_q   <= wrap_inc(grant_q, N_REQ);
              state_q    <= IDLE;
              arb_busy_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          arb_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign ack      = ack_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_q;
  assign arb_busy = arb_busy_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - randomized scoreboard bench for uart_tx_arb
`timescale 1ns/1ps
module tb_uart_tx_arb;

  localparam int N   = 3;
  localparam int LTO = 4;

  typedef logic [8:0] bq_t[$];

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   ack;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic           tx_done;
  logic [2:0]     grant_id;
  logic           arb_busy;

  logic busy_m = 1'b0;
  logic done_m = 1'b0;
  logic force_busy = 1'b0;
  bit   tail_en = 1'b0;
  int   busy_cnt = 0;
  int   tail_cnt = 0;

  int n_checks = 0;
  int n_errors = 0;
  int n_starts = 0;
  int m_ptr = 0;

  bq_t         bq[N];
  bq_t         stage[N];
  logic [10:0] exp_q[$];
  logic [10:0] exp_e;
  logic [7:0]  last_data = 8'h00;

  assign tx_busy = busy_m | force_busy;
  assign tx_done = done_m;

  always #5 clk = ~clk;

  uart_tx_arb #(.N_REQ(N), .LOCK_TO(LTO)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .req_last (req_last),
    .ack      (ack),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .grant_id (grant_id),
    .arb_busy (arb_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic fail(input string name, input string act, input string expv);
    n_checks++;
    n_errors++;
    $display("FAIL %s actual=%s expected=%s", name, act, expv);
  endtask

  // Reference arbitration: who gets the transmitter among the pending requesters
  function automatic int pick(input int ptr, input logic [N-1:0] m);
`ifdef UART_TX_ARB_PRIO_EN
    if (m[0]) return 0;
    for (int k = 0; k < N; k++) begin
      if (((ptr + k) % N) != 0 && m[(ptr + k) % N]) return (ptr + k) % N;
    end
`else
    for (int k = 0; k < N; k++) begin
      if (m[(ptr + k) % N]) return (ptr + k) % N;
    end
`endif
    return -1;
  endfunction

  function automatic bit bq_empty();
    for (int i = 0; i < N; i++) if (bq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Whole packets go out in arbitration order; a packet ends at its last byte or
  // when the requester runs dry (lock timeout), either way the pointer moves past it
  task automatic launch();
    bq_t        mq[N];
    logic [N-1:0] m;
    logic [8:0] b;
    int         r;
    for (int i = 0; i < N; i++) mq[i] = stage[i];
    forever begin
      for (int i = 0; i < N; i++) m[i] = (mq[i].size() > 0);
      if (m == '0) break;
      r = pick(m_ptr, m);
      do begin
        b = mq[r].pop_front();
        exp_q.push_back({3'(r), b[7:0]});
      end while (!b[8] && mq[r].size() > 0);
      m_ptr = (r + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      while (stage[i].size() > 0) bq[i].push_back(stage[i].pop_front());
    end
  endtask

  task automatic do_reset_recover();
    rst = 1'b0;
    for (int i = 0; i < N; i++) bq[i].delete();
    exp_q.delete();
    m_ptr = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (t < 3000 && !(exp_q.size() == 0 && bq_empty() && !arb_busy && !tx_busy)) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      fail({"idle_wait_", name}, "still busy", "idle");
      do_reset_recover();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic gap_check(input string name, input int expg);
    int t = 0;
    int g = 0;
    while (t < 500 && !tx_done) begin
      @(negedge clk);
      t++;
    end
    if (!tx_done) begin
      fail({name, "_no_done"}, "no tx_done", "tx_done");
      return;
    end
    do begin
      @(negedge clk);
      g++;
    end while (!tx_start && g < 50);
    chk(name, g, expg);
  endtask

  // Requesters: present queue head, advance on ack
  always @(posedge clk) begin
    #1;
    for (int r = 0; r < N; r++) begin
      if (rst && ack[r] && bq[r].size() > 0) void'(bq[r].pop_front());
      if (bq[r].size() > 0) begin
        req[r]            = 1'b1;
        req_data[8*r +: 8] = bq[r][0][7:0];
        req_last[r]       = bq[r][0][8];
      end else begin
        req[r]      = 1'b0;
        req_last[r] = 1'b0;
      end
    end
  end

  // Transmitter: busy for a few cycles after each start, optional stop-bit tail
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      busy_m   = 1'b0;
      done_m   = 1'b0;
      busy_cnt = 0;
      tail_cnt = 0;
    end else begin
      done_m = 1'b0;
      if (tx_start) chk("start_while_tx_busy", 32'(busy_m | force_busy), 0);
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          done_m   = 1'b1;
          tail_cnt = tail_en ? $urandom_range(0, 3) : 0;
          busy_m   = (tail_cnt > 0);
        end
      end else if (tail_cnt > 0) begin
        tail_cnt--;
        busy_m = (tail_cnt > 0);
      end
      if (tx_start) begin
        busy_m   = 1'b1;
        busy_cnt = $urandom_range(2, 6);
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      last_data = 8'h00;
    end else if (tx_start) begin
      n_starts++;
      if (exp_q.size() == 0) begin
        fail("unexpected_start", $sformatf("data=%0h grant=%0d", tx_data, grant_id), "no start");
      end else begin
        exp_e = exp_q.pop_front();
        chk("start_grant_id", grant_id, exp_e[10:8]);
        chk("start_tx_data", tx_data, exp_e[7:0]);
        chk("start_ack", ack, 32'd1 << exp_e[10:8]);
      end
      last_data = tx_data;
    end else begin
      chk("ack_without_start", ack, 0);
      chk("tx_data_hold", tx_data, last_data);
    end
  end

  initial begin
    int t;
    int starts0;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_ack", ack, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_arb_busy", arb_busy, 0);
    rst = 1'b1;
    @(negedge clk);

    stage[1].push_back({1'b1, 8'h41});
    launch();
    wait_idle("single");
    chk("single_back_to_idle", arb_busy, 0);

    stage[0].push_back({1'b1, 8'h52});
    stage[2].push_back({1'b0, 8'h4F});
    stage[2].push_back({1'b0, 8'h4B});
    stage[2].push_back({1'b1, 8'h0A});
    launch();
    gap_check("locked_gap", 3);
    wait_idle("locked");

    stage[1].push_back({1'b0, 8'h55});
    stage[0].push_back({1'b1, 8'h4C});
    launch();
`ifdef UART_TX_ARB_PRIO_EN
    gap_check("timeout_gap", 3);
`else
    gap_check("timeout_gap", 7);
`endif
    wait_idle("timeout");

    stage[1].push_back({1'b1, 8'h33});
    launch();
    t = 0;
    while (t < 200 && !tx_start) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("mid_byte_busy", arb_busy, 1);
    rst = 1'b0;
    #1;
    chk("async_rst_tx_start", tx_start, 0);
    chk("async_rst_tx_data", tx_data, 0);
    chk("async_rst_ack", ack, 0);
    chk("async_rst_grant_id", grant_id, 0);
    chk("async_rst_arb_busy", arb_busy, 0);
    m_ptr = 0;
    @(negedge clk);
    chk("rst_held_arb_busy", arb_busy, 0);
    chk("rst_held_tx_data", tx_data, 0);
    rst = 1'b1;
    @(negedge clk);

    stage[0].push_back({1'b1, 8'hA0});
    stage[0].push_back({1'b1, 8'hA1});
    stage[1].push_back({1'b1, 8'hB0});
    stage[2].push_back({1'b1, 8'hC0});
    launch();
    wait_idle("contention");

    force_busy = 1'b1;
    starts0 = n_starts;
    stage[2].push_back({1'b1, 8'h5A});
    launch();
    repeat (10) @(negedge clk);
    chk("busy_hold_no_start", n_starts - starts0, 0);
    chk("busy_hold_waiting", arb_busy, 1);
    force_busy = 1'b0;
    wait_idle("busy_hold");
    chk("busy_hold_one_start", n_starts - starts0, 1);

    tail_en = 1'b1;
    for (int b = 0; b < 25; b++) begin
      for (int r = 0; r < N; r++) begin
        int np;
        np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) begin
          int len;
          bit open;
          len  = $urandom_range(1, 3);
          open = (p == np - 1) && ($urandom_range(0, 3) == 0);
          for (int k = 0; k < len; k++) stage[r].push_back({(k == len - 1) && !open, 8'($urandom)});
        end
      end
      launch();
      wait_idle("random");
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
